// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared types and constants for the pipelined I-cache back end.
//
//   SETS       number of direct-mapped sets (power of 2, >= 2). It lives here
//              rather than on the top module because every stage struct below
//              is sized from it.
//   SET_W      set index width, $clog2(SETS)
//   TAG_W      tag width, 32 - OFFSET_W - SET_W
//   LINE_W     cache line width in bits (256)
//   OFFSET_W   byte offset width within a line (5)
//   WORD_SEL_W word index width within a line (3)
//
//   allocate_stage_t  : payload handed over by the allocate stage
//   writeback_stage_t : contents of the writeback pipeline register (wb_q)
//   fill_buf_t        : one-entry buffer holding the most recently filled line
// -----------------------------------------------------------------------------
package rv32i_types;

  localparam int SETS       = 16;
  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;
  localparam int SET_W      = $clog2(SETS);
  localparam int TAG_W      = 32 - OFFSET_W - SET_W;

  typedef struct packed {
    logic                valid;
    logic [LINE_W-1:0]   rdata;
    logic                cache_hit;
    logic [OFFSET_W-1:0] offset;
    logic [SET_W-1:0]    set;
    logic [TAG_W-1:0]    tag;
  } allocate_stage_t;

  typedef struct packed {
    logic                valid;
    logic [LINE_W-1:0]   rdata;
    logic                cache_hit;
    logic [OFFSET_W-1:0] offset;
    logic [SET_W-1:0]    set;
    logic [TAG_W-1:0]    tag;
  } writeback_stage_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [LINE_W-1:0] data;
  } fill_buf_t;

  // Builds the next wb_q contents. The payload is always taken as-is; only
  // the valid bit decides whether the slot holds a live instruction.
  function automatic writeback_stage_t wb_from_alloc(input allocate_stage_t a,
                                                     input logic            live);
    writeback_stage_t w;
    w.valid     = live;
    w.rdata     = a.rdata;
    w.cache_hit = a.cache_hit;
    w.offset    = a.offset;
    w.set       = a.set;
    w.tag       = a.tag;
    return w;
  endfunction

  // True when a probe addresses the same line as a stored {tag,set} pair.
  function automatic logic line_match(input logic [TAG_W-1:0] probe_tag,
                                      input logic [SET_W-1:0] probe_set,
                                      input logic [TAG_W-1:0] line_tag,
                                      input logic [SET_W-1:0] line_set);
    return {probe_tag, probe_set} == {line_tag, line_set};
  endfunction

endpackage

// File: rtl/icache_word_sel.sv
// -----------------------------------------------------------------------------
// icache_word_sel
//   Combinational 256->32 mux: picks the 32-bit instruction word addressed by
//   the word index (byte offset bits [4:2]) out of a cache line.
//
//   i_line     in   LINE_W      cache line
//   i_word_idx in   WORD_SEL_W  word index within the line
//   o_word     out  WORD_W      selected word
// -----------------------------------------------------------------------------
module icache_word_sel
  import rv32i_types::*;
(
  input  logic [LINE_W-1:0]     i_line,
  input  logic [WORD_SEL_W-1:0] i_word_idx,
  output logic [WORD_W-1:0]     o_word
);

  localparam int WORDS = LINE_W / WORD_W;

  // NOTE: o_word gets a default before the loop so every path assigns it and
  // no latch is inferred.
  always_comb begin
    o_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (i_word_idx == k[WORD_SEL_W-1:0]) begin
        o_word = i_line[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/icache_writeback_stage.sv
// -----------------------------------------------------------------------------
// icache_writeback_stage
//   Final stage of the pipelined I-cache, directly after the allocate stage.
//   - Registers the allocate payload (wb_q) and returns the addressed 32-bit
//     instruction word to fetch one cycle after allocate presents it.
//   - On a miss, drives a one-cycle write of the refilled line into the
//     tag/data/valid arrays.
//   - Optionally keeps a one-entry fill buffer so hit_check can pick up a
//     just-filled line before the arrays reflect it.
//
// Configuration macro: ICACHE_WB_FWD_EN
//   defined   : fill buffer and forwarding logic present.
//   undefined : no fill buffer; o_fwd_hit and o_fwd_rdata are tied to 0 and
//               hit_check must stall on a set match instead.
//
// Ports
//   i_clk          in   1        clock
//   i_rst          in   1        synchronous active-high reset
//   i_allocate     in   struct   payload from the allocate stage
//   i_read_stall   in   1        allocate stage stalled; insert a bubble
//   i_flush        in   1        fetch redirect; kill the instruction here
//   i_probe_tag    in   TAG_W    tag being checked in hit_check
//   i_probe_set    in   SET_W    set being checked in hit_check
//   o_ufp_rdata    out  32       instruction word to fetch
//   o_ufp_resp     out  1        o_ufp_rdata valid this cycle
//   o_arr_we       out  1        write strobe to tag, data and valid arrays
//   o_arr_set      out  SET_W    array write index
//   o_arr_tag      out  TAG_W    tag write data
//   o_arr_data     out  LINE_W   line write data
//   o_fwd_hit      out  1        probe matches an in-flight or buffered line
//   o_fwd_rdata    out  LINE_W   forwarded line
// -----------------------------------------------------------------------------
module icache_writeback_stage
  import rv32i_types::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  allocate_stage_t    i_allocate,
  input  logic               i_read_stall,
  input  logic               i_flush,
  input  logic [TAG_W-1:0]   i_probe_tag,
  input  logic [SET_W-1:0]   i_probe_set,
  output logic [WORD_W-1:0]  o_ufp_rdata,
  output logic               o_ufp_resp,
  output logic               o_arr_we,
  output logic [SET_W-1:0]   o_arr_set,
  output logic [TAG_W-1:0]   o_arr_tag,
  output logic [LINE_W-1:0]  o_arr_data,
  output logic               o_fwd_hit,
  output logic [LINE_W-1:0]  o_fwd_rdata
);

  writeback_stage_t r_wb_q;
  writeback_stage_t w_wb_d;
  logic             w_commit;

  // ---------------------------------------------------------------------------
  // Pipeline register. A stall lets the payload through as a bubble (the
  // allocate stage re-presents the op on release); a flush kills whatever
  // would have been captured, so it wins over a simultaneous capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wb_d = wb_from_alloc(i_allocate,
                           i_allocate.valid & ~i_read_stall & ~i_flush);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb_q <= '0;
    end else begin
      r_wb_q <= w_wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response to fetch. A flush kills the response in the same cycle.
  // ---------------------------------------------------------------------------
  assign o_ufp_resp = r_wb_q.valid & ~i_flush;

  icache_word_sel u_word_sel (
    .i_line     (r_wb_q.rdata),
    .i_word_idx (r_wb_q.offset[OFFSET_W-1:2]),
    .o_word     (o_ufp_rdata)
  );

  // Byte-within-word bits are irrelevant for a 32-bit instruction fetch.
  logic w_unused_offset_lsbs;
  assign w_unused_offset_lsbs = ^r_wb_q.offset[1:0];

  // ---------------------------------------------------------------------------
  // Array commit: one write per missed op. A flush does not block it since the
  // refilled line is valid memory data whatever fetch does next. Reset does
  // block it: the in-flight op is discarded and re-requested after reset.
  // ---------------------------------------------------------------------------
  assign w_commit   = r_wb_q.valid & ~r_wb_q.cache_hit;
  assign o_arr_we   = w_commit & ~i_rst;
  assign o_arr_set  = r_wb_q.set;
  assign o_arr_tag  = r_wb_q.tag;
  assign o_arr_data = r_wb_q.rdata;

`ifdef ICACHE_WB_FWD_EN
  // ---------------------------------------------------------------------------
  // Fill buffer: remembers the last committed line until the next miss
  // replaces it. No aging; a later miss to the same set simply overwrites it.
  // ---------------------------------------------------------------------------
  fill_buf_t r_fb;
  logic      w_match_a;
  logic      w_match_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fb <= '0;
    end else if (w_commit) begin
      r_fb.valid <= 1'b1;
      r_fb.tag   <= r_wb_q.tag;
      r_fb.set   <= r_wb_q.set;
      r_fb.data  <= r_wb_q.rdata;
    end
  end

  // Match A covers a probe to the line being committed this very cycle, so
  // hit_check needs no bubble. It is the newer data and takes priority.
  assign w_match_a   = w_commit & line_match(i_probe_tag, i_probe_set,
                                             r_wb_q.tag, r_wb_q.set);
  assign w_match_b   = r_fb.valid & line_match(i_probe_tag, i_probe_set,
                                               r_fb.tag, r_fb.set);
  assign o_fwd_hit   = w_match_a | w_match_b;
  assign o_fwd_rdata = w_match_a ? r_wb_q.rdata : r_fb.data;
`else
  // Forwarding absent: hit_check stalls on a set match instead.
  logic w_unused_probe;
  assign w_unused_probe = ^{i_probe_tag, i_probe_set};
  assign o_fwd_hit      = 1'b0;
  assign o_fwd_rdata    = '0;
`endif

endmodule

// File: tb/tb_icache_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_icache_writeback_stage
//   Self-checking bench for icache_writeback_stage. A behavioural model tracks
//   "which op sits in the writeback slot" and "which line was filled last";
//   a compare process checks every output against it on every negedge, and a
//   directed sequence pins the model with hand-computed literals. Works with
//   and without ICACHE_WB_FWD_EN defined.
// -----------------------------------------------------------------------------
module tb_icache_writeback_stage;
  import rv32i_types::*;

`ifdef ICACHE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  allocate_stage_t   alloc;
  logic              stall;
  logic              flush;
  logic [TAG_W-1:0]  ptag;
  logic [SET_W-1:0]  pset;

  logic [WORD_W-1:0] ufp_rdata;
  logic              ufp_resp;
  logic              arr_we;
  logic [SET_W-1:0]  arr_set;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_data;
  logic              fwd_hit;
  logic [LINE_W-1:0] fwd_rdata;

  icache_writeback_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_allocate   (alloc),
    .i_read_stall (stall),
    .i_flush      (flush),
    .i_probe_tag  (ptag),
    .i_probe_set  (pset),
    .o_ufp_rdata  (ufp_rdata),
    .o_ufp_resp   (ufp_resp),
    .o_arr_we     (arr_we),
    .o_arr_set    (arr_set),
    .o_arr_tag    (arr_tag),
    .o_arr_data   (arr_data),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_rdata  (fwd_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the op accepted at the last edge, and the last miss line.
  // ---------------------------------------------------------------------------
  allocate_stage_t   m_slot;
  bit                m_slot_live;
  bit                m_fill_live;
  logic [TAG_W-1:0]  m_fill_tag;
  logic [SET_W-1:0]  m_fill_set;
  logic [LINE_W-1:0] m_fill_line;
  bit                m_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_slot      <= '0;
      m_slot_live <= 1'b0;
      m_fill_live <= 1'b0;
      m_fill_tag  <= '0;
      m_fill_set  <= '0;
      m_fill_line <= '0;
      m_ready     <= 1'b1;
    end else begin
      if (m_slot_live && !m_slot.cache_hit) begin
        m_fill_live <= 1'b1;
        m_fill_tag  <= m_slot.tag;
        m_fill_set  <= m_slot.set;
        m_fill_line <= m_slot.rdata;
      end
      m_slot      <= alloc;
      m_slot_live <= alloc.valid && !stall && !flush;
    end
  end

  logic [LINE_W-1:0] e_shift;
  bit                e_miss, e_a, e_b;
  logic [LINE_W-1:0] e_frd;

  always @(negedge clk) begin
    if (m_ready) begin
      e_shift = m_slot.rdata >> (WORD_W * int'(m_slot.offset >> 2));
      e_miss  = m_slot_live && !m_slot.cache_hit;
      e_a     = FWD && e_miss && ptag == m_slot.tag && pset == m_slot.set;
      e_b     = FWD && m_fill_live && ptag == m_fill_tag && pset == m_fill_set;
      e_frd   = !FWD ? '0 : (e_a ? m_slot.rdata : m_fill_line);
      check("m_ufp_resp",  ufp_resp,  (m_slot_live && !flush));
      check("m_ufp_rdata", ufp_rdata, e_shift[WORD_W-1:0]);
      check("m_arr_we",    arr_we,    (e_miss && !rst));
      check("m_arr_set",   arr_set,   m_slot.set);
      check("m_arr_tag",   arr_tag,   m_slot.tag);
      check("m_arr_data",  arr_data,  m_slot.rdata);
      check("m_fwd_hit",   fwd_hit,   (e_a || e_b));
      check("m_fwd_rdata", fwd_rdata, e_frd);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / WORD_W; i++) l[i*WORD_W +: WORD_W] = $urandom;
    return l;
  endfunction

  function automatic allocate_stage_t mk_op(input logic hit, input logic [OFFSET_W-1:0] off,
                                            input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                                            input logic [LINE_W-1:0] line);
    allocate_stage_t a;
    a.valid     = 1'b1;
    a.rdata     = line;
    a.cache_hit = hit;
    a.offset    = off;
    a.set       = s;
    a.tag       = t;
    return a;
  endfunction

  logic [LINE_W-1:0] line1, line2, line5, line6;
  logic [TAG_W-1:0]  tag_t, tag6;

  initial begin
    rst   = 1'b1;
    alloc = '0;
    stall = 1'b0;
    flush = 1'b0;
    ptag  = '0;
    pset  = '0;
    tag_t = TAG_W'(23'h5A5A5);
    tag6  = TAG_W'(23'h01234);

    // Reset state
    tick();
    sample();
    check("rst_ufp_resp",  ufp_resp,  1'b0);
    check("rst_arr_we",    arr_we,    1'b0);
    check("rst_fwd_hit",   fwd_hit,   1'b0);
    check("rst_ufp_rdata", ufp_rdata, 32'h0);
    check("rst_arr_data",  arr_data,  '0);

    // 1: hit returns word 3 one cycle later, no array write
    tick();
    rst   = 1'b0;
    line1 = rand_line();
    line1[3*WORD_W +: WORD_W] = 32'hDEADBEEF;
    alloc = mk_op(1'b1, 5'h0C, 4'h2, TAG_W'(9), line1);
    tick();
    alloc.valid = 1'b0;
    sample();
    check("t1_ufp_resp",  ufp_resp,  1'b1);
    check("t1_ufp_rdata", ufp_rdata, 32'hDEADBEEF);
    check("t1_arr_we",    arr_we,    1'b0);

    // 2/3: miss commits; probe in commit cycle (match A), then fill buffer
    line2 = rand_line();
    alloc = mk_op(1'b0, 5'h04, 4'h7, tag_t, line2);
    tick();
    alloc.valid = 1'b0;
    ptag = tag_t;
    pset = 4'h7;
    sample();
    check("t2_arr_we",     arr_we,    1'b1);
    check("t2_arr_set",    arr_set,   4'h7);
    check("t2_arr_tag",    arr_tag,   tag_t);
    check("t3_fwd_hit",    fwd_hit,   FWD);
    check("t3_fwd_rdata",  fwd_rdata, FWD ? line2 : '0);
    tick();
    sample();
    check("t2_arr_we_once", arr_we,    1'b0);
    check("t2_fb_fwd_hit",  fwd_hit,   FWD);
    check("t2_fb_rdata",    fwd_rdata, FWD ? line2 : '0);

    // 4: three stalled cycles give bubbles, release gives exactly one response
    alloc = mk_op(1'b1, 5'h10, 4'h1, TAG_W'(3), rand_line());
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      check("t4_stall_resp", ufp_resp, 1'b0);
    end
    stall = 1'b0;
    tick();
    alloc.valid = 1'b0;
    sample();
    check("t4_release_resp", ufp_resp, 1'b1);
    tick();
    sample();
    check("t4_no_dup_resp", ufp_resp, 1'b0);

    // 5: flush on a miss keeps the commit, kills response and the next capture
    line5 = rand_line();
    alloc = mk_op(1'b0, 5'h00, 4'h5, TAG_W'(77), line5);
    tick();
    alloc = mk_op(1'b1, 5'h08, 4'h0, TAG_W'(1), rand_line());
    flush = 1'b1;
    sample();
    check("t5_flush_resp",   ufp_resp, 1'b0);
    check("t5_flush_arr_we", arr_we,   1'b1);
    check("t5_flush_data",   arr_data, line5);
    tick();
    flush = 1'b0;
    alloc.valid = 1'b0;
    sample();
    check("t5_after_resp",   ufp_resp, 1'b0);
    check("t5_after_arr_we", arr_we,   1'b0);

    // 6: reset mid-commit discards the miss and clears everything
    line6 = rand_line();
    alloc = mk_op(1'b0, 5'h14, 4'h3, tag6, line6);
    tick();
    alloc = mk_op(1'b1, 5'h00, 4'h3, tag6, rand_line());
    rst  = 1'b1;
    ptag = tag6;
    pset = 4'h3;
    sample();
    check("t6_rst_arr_we", arr_we, 1'b0);
    tick();
    sample();
    check("t6_ufp_resp",  ufp_resp,  1'b0);
    check("t6_arr_we",    arr_we,    1'b0);
    check("t6_fwd_hit",   fwd_hit,   1'b0);
    check("t6_fwd_rdata", fwd_rdata, '0);
    check("t6_arr_data",  arr_data,  '0);
    check("t6_ufp_rdata", ufp_rdata, 32'h0);

    // Random traffic over a small tag/set pool so probes collide often
    tick();
    rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      alloc = mk_op(1'($urandom_range(0, 1)), 5'($urandom), SET_W'($urandom_range(0, 3)),
                    TAG_W'($urandom_range(0, 3)), rand_line());
      alloc.valid = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 8);
      rst   = ($urandom_range(0, 99) < 2);
      ptag  = TAG_W'($urandom_range(0, 3));
      pset  = SET_W'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    alloc.valid = 1'b0;
    tick();
    sample();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
